// File: rtl/pair_sum_reporter.sv
// pair_sum_reporter: sums ASCII two-digit values, reports the total as decimal ASCII over a UART tx handshake (COUNT_REPORT_EN appends ",NNNN" pair count)
module pair_sum_reporter #(
  parameter int SUM_W  = 20,
  parameter int DIGITS = 7
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_xmit,
  output logic [SUM_W-1:0] total,
  output logic             busy,
  output logic             err
);
  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(SUM_W + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  typedef enum logic [2:0] {ACC, CONV, LOAD, XMIT, GUARD, WAIT} state_t;
  typedef enum logic [2:0] {PH_TOT, PH_COM, PH_CCV, PH_CNT, PH_NL, PH_DONE} phase_t;
  state_t           r_state, w_next;
  phase_t           r_ph;
  logic [SUM_W-1:0] r_total, r_bin;
  logic [BW-1:0]    r_bcd, w_adj;
  logic [CW-1:0]    r_cnt, w_conv_last;
  logic [IW-1:0]    r_idx;
  logic [3:0]       r_tens, w_digit;
  logic             r_pend, r_started, r_err;
  logic [7:0]       r_tx_data;
  logic [6:0]       w_pair;
  logic [SUM_W:0]   w_sum;
  logic             w_is_dig, w_is_ws, w_is_eq, w_skip, w_last_conv, w_dig_ph;
`ifdef COUNT_REPORT_EN
  logic [9:0]       r_pairs;
`endif

  assign w_is_dig    = in_data >= 8'h30 && in_data <= 8'h39;
  assign w_is_ws     = in_data == 8'h0A || in_data == 8'h0D || in_data == 8'h20;
  assign w_is_eq     = in_data == 8'h3D;
  assign w_pair      = 7'(r_tens) * 7'd10 + 7'(in_data[3:0]);
  assign w_sum       = {1'b0, r_total} + (SUM_W+1)'(w_pair);
  assign w_digit     = r_bcd[4*r_idx +: 4];
`ifdef COUNT_REPORT_EN
  assign w_dig_ph    = r_ph == PH_TOT || r_ph == PH_CNT;
  assign w_conv_last = r_ph == PH_CCV ? CW'(9) : CW'(SUM_W - 1);
`else
  assign w_dig_ph    = r_ph == PH_TOT;
  assign w_conv_last = CW'(SUM_W - 1);
`endif
  assign w_last_conv = r_cnt == w_conv_last;
  assign w_skip      = r_ph == PH_TOT && w_digit == 4'd0 && !r_started && r_idx != '0;
  assign tx_data     = r_tx_data;
  assign tx_xmit     = r_state == XMIT && tx_ready;
  assign total       = r_total;
  assign busy        = r_state != ACC;
  assign err         = r_err;

  // double-dabble correction: add 3 to every BCD nibble of 5 or more before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++)
      w_adj[4*k +: 4] = r_bcd[4*k +: 4] >= 4'd5 ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
  end

  // next-state: accumulate, convert, then send one character per LOAD/XMIT/GUARD/WAIT loop
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACC:     w_next = (in_valid && w_is_eq) ? CONV : ACC;
      CONV:    w_next = w_last_conv ? LOAD : CONV;
      LOAD:    w_next = w_skip ? LOAD : XMIT;
      XMIT:    w_next = tx_ready ? GUARD : XMIT;
      GUARD:   w_next = WAIT;
      WAIT:    w_next = !tx_ready ? WAIT : r_ph == PH_DONE ? ACC :
`ifdef COUNT_REPORT_EN
                        r_ph == PH_CCV ? CONV :
`endif
                        LOAD;
      default: w_next = ACC;
    endcase
  end

  // state register
  always_ff @(posedge sysclk) r_state <= reset ? ACC : w_next;

  // datapath: accumulator, BCD converter and character sequencer
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_total   <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_tens    <= '0;
      r_pend    <= 1'b0;
      r_started <= 1'b0;
      r_err     <= 1'b0;
      r_tx_data <= '0;
      r_ph      <= PH_TOT;
`ifdef COUNT_REPORT_EN
      r_pairs   <= '0;
`endif
    end else begin
      if (in_valid && r_state != ACC) r_err <= 1'b1;
      case (r_state)
        ACC: if (in_valid) begin
          if (w_is_dig && !r_pend) begin
            r_tens <= in_data[3:0];
            r_pend <= 1'b1;
          end else if (w_is_dig) begin
            r_pend  <= 1'b0;
            r_total <= w_sum[SUM_W] ? '1 : w_sum[SUM_W-1:0];
            if (w_sum[SUM_W]) r_err <= 1'b1;
`ifdef COUNT_REPORT_EN
            if (r_pairs != 10'd999) r_pairs <= r_pairs + 1'b1;
`endif
          end else if (w_is_ws || w_is_eq) begin
            if (r_pend) r_err <= 1'b1;
            r_pend <= 1'b0;
          end else
            r_err <= 1'b1;
          if (w_is_eq) begin
            r_bin     <= r_total;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_idx     <= IW'(DIGITS - 1);
            r_started <= 1'b0;
            r_ph      <= PH_TOT;
          end
        end
        CONV: begin
          {r_bcd, r_bin} <= {w_adj[BW-2:0], r_bin, 1'b0};
          r_cnt <= r_cnt + 1'b1;
`ifdef COUNT_REPORT_EN
          if (w_last_conv && r_ph == PH_CCV) r_ph <= PH_CNT;
`endif
        end
        LOAD: begin
          if (w_dig_ph) begin
            if (!w_skip) r_tx_data <= 8'h30 + {4'h0, w_digit};
            if (!w_skip) r_started <= 1'b1;
            if (r_idx != '0) r_idx <= r_idx - 1'b1;
`ifdef COUNT_REPORT_EN
            else r_ph <= r_ph == PH_TOT ? PH_COM : PH_NL;
`else
            else r_ph <= PH_NL;
`endif
          end else if (r_ph == PH_NL) begin
            r_tx_data <= 8'h0A;
            r_ph      <= PH_DONE;
          end
`ifdef COUNT_REPORT_EN
          else if (r_ph == PH_COM) begin
            r_tx_data <= 8'h2C;
            r_ph      <= PH_CCV;
          end
`endif
        end
        WAIT: if (tx_ready) begin
          if (r_ph == PH_DONE) begin
            r_total <= '0;
            r_pend  <= 1'b0;
`ifdef COUNT_REPORT_EN
            r_pairs <= '0;
`endif
          end
`ifdef COUNT_REPORT_EN
          if (r_ph == PH_CCV) begin
            r_bin <= SUM_W'(r_pairs) << (SUM_W - 10);
            r_bcd <= '0;
            r_cnt <= '0;
            r_idx <= IW'(3);
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pair_sum_reporter.sv
// tb_pair_sum_reporter: scoreboard bench, expected tx bytes queued by stimulus and popped by a tx-side monitor
module tb_pair_sum_reporter;
  logic        sysclk = 1'b0, reset = 1'b1, in_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_xmit, busy, err;
  logic [19:0] total;
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  exp_q[$];

  pair_sum_reporter dut (
    .sysclk(sysclk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_xmit(tx_xmit), .total(total), .busy(busy), .err(err)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge sysclk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 5000) begin
      @(posedge sysclk);
      #1 k++;
    end
    chk(name, {31'd0, exp_q.size() == 0 && !busy}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_xmit"}, 32'(tx_xmit), 32'd0);
    chk({tag, "_total"}, 32'(total), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    exp_q.delete();
    @(posedge sysclk);
    #1 check_reset_outputs(tag);
    reset = 1'b0;
  endtask

  // ua_tx model and scoreboard monitor
  initial forever begin
    @(negedge sysclk);
    if (!reset && tx_xmit) begin
      chk("xmit_ready", 32'(tx_ready), 32'd1);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL tx_extra: got 0x%02h expected no transmission", tx_data);
      end else
        chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      @(posedge sysclk);
      #1 tx_ready = 1'b0;
      @(negedge sysclk);
      chk("xmit_pulse", 32'(tx_xmit), 32'd0);
      repeat (2) @(posedge sysclk);
      #1 tx_ready = 1'b1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge sysclk);
    #1 do_reset("rst0");
    // basic sum 98 + 89 = 187
    expect_str("187\n");
    send_str("98\n89");
    chk("sum_187", 32'(total), 32'd187);
    send_str("\n=");
    chk("busy_conv", 32'(busy), 32'd1);
    wait_idle("drain_187");
    chk("err_187", 32'(err), 32'd0);
    chk("total_clr_187", 32'(total), 32'd0);
    // empty report
    expect_str("0\n");
    send("=");
    chk("total_zero", 32'(total), 32'd0);
    wait_idle("drain_zero");
    chk("busy_zero", 32'(busy), 32'd0);
    // saturation
    for (int i = 0; i < 10600; i++) send_str("99");
    chk("sat_total", 32'(total), 32'hFFFFF);
    chk("sat_err", 32'(err), 32'd1);
    expect_str("1048575\n");
    send("=");
    wait_idle("drain_sat");
    // dangling digit, then a byte strobed during send
    do_reset("rst1");
    send_str("9\n");
    chk("dangling_err", 32'(err), 32'd1);
    expect_str("12\n");
    send_str("12=");
    @(posedge sysclk);
    #1 send("5");
    chk("drop_total", 32'(total), 32'd12);
    chk("drop_busy", 32'(busy), 32'd1);
    wait_idle("drain_12");
    chk("drop_err", 32'(err), 32'd1);
    // reset while waiting after the second digit of 187
    do_reset("rst2");
    expect_str("187\n");
    send_str("98\n89\n=");
    k = 0;
    while (exp_q.size() > 2 && k < 2000) begin
      @(posedge sysclk);
      #1 k++;
    end
    chk("two_digits_sent", 32'(exp_q.size()), 32'd2);
    @(posedge sysclk);
    #1 do_reset("rst_wait");
    repeat (40) @(posedge sysclk);
    #1 chk("idle_after_abort", 32'(busy), 32'd0);
    expect_str("5\n");
    send_str("05=");
    wait_idle("drain_5");
    // whitespace separated pairs, optional count report
`ifdef COUNT_REPORT_EN
    expect_str("187,0002\n");
`else
    expect_str("187\n");
`endif
    send_str("98 89 =");
    wait_idle("drain_report");
    chk("err_report", 32'(err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pair_sum_reporter.md
Name: pair_sum_reporter

Overview:
- Downstream stage of the per-line max-digit solver. Consumes its ASCII two-digit results ("98", "89", ...) as a byte stream from the UART receiver.
- Accumulates the sum of all two-digit values. On an end marker, converts the total to decimal and transmits it as ASCII through the UART transmitter handshake.
- Sits between ua_rx (value/recd) and ua_tx (data/xmit/ready) in the top-level.

Parameters:
- SUM_W, 20, width of the binary accumulator (max 1048575).
- DIGITS, 7, decimal digits produced by the converter; must cover 2^SUM_W-1.

Ports:
- sysclk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_data  input  8  received byte
- in_valid  input  1  one-cycle strobe: in_data valid
- tx_ready  input  1  transmitter idle (ua_tx ready)
- tx_data  output  8  byte to transmit
- tx_xmit  output  1  one-cycle transmit request
- total  output  SUM_W  current accumulator value
- busy  output  1  high outside ACC state
- err  output  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (synchronous, active-high): tx_data=0, tx_xmit=0, total=0, busy=0, err=0, pending digit cleared, state=ACC. Reset mid-conversion or mid-send aborts immediately, with no further tx_xmit.
- States: ACC -> CONV -> LOAD -> XMIT -> GUARD -> WAIT -> (LOAD | ACC).
- ACC, on in_valid:
  - '0'-'9' with no pending digit: store tens = in_data-8'h30; set pending.
  - '0'-'9' with pending: total <= total + tens*10 + ones; clear pending. The update is visible on total the cycle after the strobe.
  - 8'h0A, 8'h0D, 8'h20: ignored if nothing is pending. If a digit is pending, set err and discard it.
  - '=' (8'h3D): if a digit is pending, set err and discard it. Then go to CONV.
  - Any other byte: set err; byte ignored.
- Saturation: if the sum exceeds 2^SUM_W-1, total holds all-ones and err is set.
- CONV: shift-add-3 binary-to-BCD, one bit per cycle. Exactly SUM_W cycles; the BCD register is DIGITS*4 bits.
- LOAD: select the next digit, most significant first. Leading zeros are suppressed, but the least significant digit is always sent. tx_data = 8'h30 + digit. After the last digit, tx_data = 8'h0A.
- XMIT: waits until tx_ready=1, then drives tx_xmit=1 for exactly one cycle.
- GUARD: one cycle with tx_xmit=0, so ua_tx has registered busy.
- WAIT: holds until tx_ready=1. If more characters remain, go to LOAD. After the 8'h0A character: total<=0, pending cleared, go to ACC (err unchanged).
- in_valid outside ACC: byte dropped, err set.
- busy=1 in every state except ACC.
- total=0 at '=': transmits "0\n".

Optional Feature:
- Macro COUNT_REPORT_EN.
- Defined:
  - A 10-bit pair counter increments on each completed pair and saturates at 999.
  - After the total digits, the block sends ',' (8'h2C), then the count as exactly 4 zero-padded decimal digits, then 8'h0A.
  - The count is converted by the same shift-add-3 engine: a second CONV pass of 10 cycles after the comma.
  - The counter clears together with total.
- Undefined: no counter logic; output is the total digits followed by 8'h0A only.

Test Plan:
- Reset, then "98\n89\n=" -> total=187 after the last pair; tx bytes 31 38 37 0A. Each tx_xmit is a single cycle and is never asserted while tx_ready=0. err=0.
- "=" with no data -> tx bytes 30 0A; total stays 0; busy returns low after 0A completes.
- 10600 copies of "99" (sum 1049400 > 1048575) then "=" -> total=1048575, err=1, tx "1048575\n".
- "9\n" then "12=" -> err=1, 9 discarded, tx "12\n". A byte strobed during SEND is dropped and leaves the output unchanged.
- Assert reset during WAIT after the 2nd digit of "187" -> no further tx_xmit, all outputs at reset values next cycle. A following "05=" sends "5\n".
- With COUNT_REPORT_EN: "98 89 =" -> tx "187,0002\n".
